// File: rtl/id_ex_if.sv
// Decode-to-execute bundle: decoded instruction, operands, writeback
// bypass inputs, stall/flush controls and the registered execute view.
interface id_ex_if #(
    parameter int CNT_W = 16
);
    logic [31:0]    inst_i;
    logic [31:0]    inst_addr_i;
    logic [31:0]    rs1_data_i;
    logic [31:0]    rs2_data_i;
    logic [4:0]     rs1_addr_i;
    logic [4:0]     rs2_addr_i;
    logic           rs1_rd_i;
    logic           rs2_rd_i;
    logic [4:0]     rd_addr_i;
    logic           rd_wen_i;
    logic [4:0]     wb_addr_i;
    logic [31:0]    wb_data_i;
    logic           wb_wen_i;
    logic           hold_i;
    logic           flush_i;
    logic [31:0]    inst_o;
    logic [31:0]    inst_addr_o;
    logic [31:0]    rs1_data_o;
    logic [31:0]    rs2_data_o;
    logic [4:0]     rd_addr_o;
    logic           rd_wen_o;
    logic           valid_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output inst_i, inst_addr_i, rs1_data_i, rs2_data_i,
        output rs1_addr_i, rs2_addr_i, rs1_rd_i, rs2_rd_i,
        output rd_addr_i, rd_wen_i, wb_addr_i, wb_data_i, wb_wen_i,
        output hold_i, flush_i,
        input  inst_o, inst_addr_o, rs1_data_o, rs2_data_o,
        input  rd_addr_o, rd_wen_o, valid_o, flush_cnt_o
    );

    modport slave (
        input  inst_i, inst_addr_i, rs1_data_i, rs2_data_i,
        input  rs1_addr_i, rs2_addr_i, rs1_rd_i, rs2_rd_i,
        input  rd_addr_i, rd_wen_i, wb_addr_i, wb_data_i, wb_wen_i,
        input  hold_i, flush_i,
        output inst_o, inst_addr_o, rs1_data_o, rs2_data_o,
        output rd_addr_o, rd_wen_o, valid_o, flush_cnt_o
    );
endinterface

// File: rtl/id_ex.sv
// ID/EX pipeline register with stall, flush-to-bubble and writeback
// bypass applied both on capture and to operands parked during a stall.
module id_ex #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int          CNT_W    = 16
) (
    input logic   clk,
    input logic   rst,
    id_ex_if.slave bus
);
    logic [31:0]      inst_q;
    logic [31:0]      addr_q;
    logic [31:0]      rs1_q;
    logic [31:0]      rs2_q;
    logic [4:0]       rd_q;
    logic             rd_wen_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       rs1_a_q;
    logic [4:0]       rs2_a_q;
    logic             rs1_rd_q;
    logic             rs2_rd_q;

    logic wb_ok;
    logic hit1_new;
    logic hit2_new;
    logic hit1_old;
    logic hit2_old;

    // x0 writes never patch an operand
    assign wb_ok = bus.wb_wen_i && (bus.wb_addr_i != 5'd0);

    assign hit1_new = wb_ok && bus.rs1_rd_i
                    && (bus.rs1_addr_i == bus.wb_addr_i);
    assign hit2_new = wb_ok && bus.rs2_rd_i
                    && (bus.rs2_addr_i == bus.wb_addr_i);
    assign hit1_old = wb_ok && valid_q && rs1_rd_q
                    && (rs1_a_q == bus.wb_addr_i);
    assign hit2_old = wb_ok && valid_q && rs2_rd_q
                    && (rs2_a_q == bus.wb_addr_i);

    always_ff @(posedge clk) begin
        if (rst || bus.flush_i) begin
            inst_q   <= NOP_INST;
            addr_q   <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            rd_wen_q <= 1'b0;
            valid_q  <= 1'b0;
            rs1_a_q  <= '0;
            rs2_a_q  <= '0;
            rs1_rd_q <= 1'b0;
            rs2_rd_q <= 1'b0;
            if (rst) begin
                cnt_q <= '0;
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else if (bus.hold_i) begin
            if (hit1_old) begin
                rs1_q <= bus.wb_data_i;
            end
            if (hit2_old) begin
                rs2_q <= bus.wb_data_i;
            end
        end else begin
            inst_q   <= bus.inst_i;
            addr_q   <= bus.inst_addr_i;
            rs1_q    <= hit1_new ? bus.wb_data_i : bus.rs1_data_i;
            rs2_q    <= hit2_new ? bus.wb_data_i : bus.rs2_data_i;
            rd_q     <= bus.rd_addr_i;
            rd_wen_q <= bus.rd_wen_i;
            valid_q  <= 1'b1;
            rs1_a_q  <= bus.rs1_addr_i;
            rs2_a_q  <= bus.rs2_addr_i;
            rs1_rd_q <= bus.rs1_rd_i;
            rs2_rd_q <= bus.rs2_rd_i;
        end
    end

    assign bus.inst_o      = inst_q;
    assign bus.inst_addr_o = addr_q;
    assign bus.rs1_data_o  = rs1_q;
    assign bus.rs2_data_o  = rs2_q;
    assign bus.rd_addr_o   = rd_q;
    assign bus.rd_wen_o    = rd_wen_q;
    assign bus.valid_o     = valid_q;
    assign bus.flush_cnt_o = cnt_q;
endmodule

// File: doc/id_ex.md
# id_ex

Pipeline register between the decode stage and the execute stage. Each cycle it captures the decoded instruction, its address, operand values and destination info. It presents them to execute on the next cycle. It supports a stall (hold) and a flush (bubble insertion on a taken jump), and it applies writeback bypass. Bypass patches operand values that decode read from the register file before an in-flight execute result was written back. This covers both newly captured operands and operands already parked during a stall.

## Interface
Parameters:
- NOP_INST, 32'h0000_0013 (addi x0,x0,0): instruction presented on reset and on bubbles.
- CNT_W, 16: width of the flush statistics counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- inst_i  input  32  decoded instruction word.
- inst_addr_i  input  32  instruction address.
- rs1_data_i  input  32  operand 1 value from register file / decode.
- rs2_data_i  input  32  operand 2 value (register value or immediate).
- rs1_addr_i  input  5  source register 1 index.
- rs2_addr_i  input  5  source register 2 index.
- rs1_rd_i  input  1  operand 1 comes from a register (bypass-eligible).
- rs2_rd_i  input  1  operand 2 comes from a register (0 when it carries an immediate).
- rd_addr_i  input  5  destination register.
- rd_wen_i  input  1  destination write enable.
- wb_addr_i  input  5  execute-stage writeback address (same cycle).
- wb_data_i  input  32  execute-stage writeback data.
- wb_wen_i  input  1  execute-stage writeback enable.
- hold_i  input  1  stall: keep current contents.
- flush_i  input  1  taken jump: replace contents with a bubble.
- inst_o  output  32  registered instruction.
- inst_addr_o  output  32  registered address.
- rs1_data_o  output  32  registered operand 1.
- rs2_data_o  output  32  registered operand 2.
- rd_addr_o  output  5  registered destination.
- rd_wen_o  output  1  registered write enable.
- valid_o  output  1  1 = real instruction, 0 = bubble.
- flush_cnt_o  output  CNT_W  saturating count of bubbles inserted by flush.

## Operation
- Update priority at each edge: rst > flush_i > hold_i > load.
- rst state:
  - inst_o = NOP_INST.
  - inst_addr_o, rs1_data_o, rs2_data_o, rd_addr_o = 0.
  - rd_wen_o = 0, valid_o = 0, flush_cnt_o = 0.
  - Internal stored rs1/rs2 addresses and rd flags = 0.
- Flush:
  - Load the bubble: NOP_INST, zero data/address, rd_wen_o = 0, valid_o = 0.
  - flush_cnt_o increments by 1 and holds at all-ones (no wrap).
  - Flush with hold_i = 1 still flushes.
- Hold:
  - All outputs keep their values, except for in-place bypass.
  - In-place bypass: if wb_wen_i, wb_addr_i != 0, the stored rs1_rd flag = 1 and the stored rs1 address == wb_addr_i, then rs1_data_o <= wb_data_i. Same rule for rs2.
  - A bubble (valid_o = 0) is never patched.
- Load:
  - Capture all inputs and set valid_o = 1.
  - Capture rs1_addr_i, rs2_addr_i, rs1_rd_i and rs2_rd_i into internal state.
  - Capture bypass: if wb_wen_i, wb_addr_i != 0, rs1_rd_i and rs1_addr_i == wb_addr_i, capture wb_data_i instead of rs1_data_i. Same rule for rs2.
- x0 is never bypassed, so writes to x0 are ignored for operand patching.
- When rs1 and rs2 both match wb_addr_i, both are patched.

## Timing
- Latency: 1 cycle from inputs to outputs.
- No combinational path from any input to any output.
- hold_i and flush_i are sampled at the same edge as the data.
- Flush takes effect on the next cycle's outputs. The instruction presented during the flush cycle is discarded.
- Hold deasserting: the next edge loads fresh inputs.
- Reset asserted mid-stall or mid-flush: outputs reach the reset values one edge later, and flush_cnt_o clears.
- Saturation: with flush_cnt_o = 2^CNT_W−1, a further flush keeps it at 2^CNT_W−1.

## Test plan
- Reset: hold rst = 1 for 2 cycles → inst_o = 32'h13, valid_o = 0, rd_wen_o = 0, flush_cnt_o = 0.
- Plain load and bypass: inst_i = 32'h00308093, rs1_data_i = 5, rd_addr_i = 1, rd_wen_i = 1; next cycle inst_o = 32'h00308093, rs1_data_o = 5, valid_o = 1. Then load rs1_addr_i = 3, rs1_rd_i = 1, rs1_data_i = 7 with wb_addr_i = 3, wb_data_i = 9, wb_wen_i = 1 → rs1_data_o = 9.
- Immediate and x0 exclusion:
  - rs2_rd_i = 0 with rs2_addr_i == wb_addr_i = 3 → rs2_data_o = rs2_data_i (immediate unchanged).
  - wb_addr_i = 0 with rs1_addr_i = 0 → no patch.
- Hold with in-place bypass: hold_i = 1 for 3 cycles with a stored instruction whose rs2 = x4. In cycle 2, drive wb_addr_i = 4, wb_data_i = 32'hDEAD_BEEF → rs2_data_o = 32'hDEADBEEF and all other outputs unchanged. After release, the next input is loaded.
- Flush priority and count: flush_i = 1 and hold_i = 1 together → valid_o = 0, inst_o = 32'h13, flush_cnt_o = 1. Then 3 further flushes → flush_cnt_o = 4.
- Saturation and reset: with CNT_W = 2, apply 5 flushes → flush_cnt_o = 3. Then assert rst during an active hold → all outputs return to reset values on the next edge.
